// File: rtl/m_req_flit_fifo.sv
// Purpose : packet-aware store-and-forward flit FIFO from the memory request
//           upload stage to the ring request port; a packet is offered to the
//           ring only after its tail flit is stored.
// Latency : tail accepted at edge N -> v_flit_out high from cycle N+1; output is
//           show-ahead (head-of-FIFO flit visible while v_flit_out is high).
// Backpr. : req_fifo_rdy drops when all DEPTH entries are used; ring_rdy_in low
//           holds the output flit; one write and one read per cycle sustained.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   flit_in/ctrl_in     flit and type (01 head, 10 body, 11 tail, 00 illegal)
//   v_flit_in           input flit valid
//   req_fifo_rdy        space available toward the upload stage
//   flit_out/ctrl_out   head-of-FIFO flit and type toward the ring
//   v_flit_out          output valid (at least one complete packet stored)
//   ring_rdy_in         ring accepts the output flit this cycle
//   pkt_cnt             number of complete packets stored
//   proto_err           sticky: illegal flit type sequence seen
//   ovf_err             sticky: v_flit_in while req_fifo_rdy low
module m_req_flit_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      flit_in,
  input  logic [1:0]       ctrl_in,
  input  logic             v_flit_in,
  output logic             req_fifo_rdy,
  output logic [15:0]      flit_out,
  output logic [1:0]       ctrl_out,
  output logic             v_flit_out,
  input  logic             ring_rdy_in,
  output logic [PTR_W:0]   pkt_cnt,
  output logic             proto_err,
  output logic             ovf_err
);

  localparam logic [1:0]     CTRL_HEAD = 2'b01;
  localparam logic [1:0]     CTRL_BODY = 2'b10;
  localparam logic [1:0]     CTRL_TAIL = 2'b11;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    WAIT_HEAD,
    IN_PKT
  } chk_state_t;

  // storage: {ctrl, flit}
  logic [17:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;

  chk_state_t state_q;
  chk_state_t state_d;

  logic legal;
  logic wr_en;
  logic rd_en;
  logic wr_tail;
  logic rd_tail;

  assign req_fifo_rdy = (cnt != FULL_CNT);

  // show-ahead read port
  assign flit_out   = mem[rd_ptr][15:0];
  assign ctrl_out   = mem[rd_ptr][17:16];
  // Only complete packets are offered, so once the head is visible the rest
  // of the packet is already stored and the ring sees no bubbles.
  assign v_flit_out = (pkt_cnt != '0);

  assign rd_en   = v_flit_out & ring_rdy_in;
  assign wr_tail = wr_en & (ctrl_in == CTRL_TAIL);
  assign rd_tail = rd_en & (ctrl_out == CTRL_TAIL);

  // input checker: classifies the incoming flit type against packet framing
  always_comb begin
    state_d = state_q;
    legal   = 1'b0;
    case (state_q)
      WAIT_HEAD: legal = (ctrl_in == CTRL_HEAD);
      IN_PKT:    legal = (ctrl_in == CTRL_BODY) || (ctrl_in == CTRL_TAIL);
      default:   legal = 1'b0;
    endcase

    // A full FIFO drops the flit before the checker sees it, so the framing
    // state only advances on flits that are actually stored.
    wr_en = v_flit_in & req_fifo_rdy & legal;

    if (wr_en) begin
      case (state_q)
        WAIT_HEAD: state_d = IN_PKT;
        IN_PKT:    if (ctrl_in == CTRL_TAIL) state_d = WAIT_HEAD;
        default:   state_d = WAIT_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= WAIT_HEAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      pkt_cnt   <= '0;
      proto_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase

      // tail in and tail out in the same cycle leave the packet count alone
      case ({wr_tail, rd_tail})
        2'b10:   pkt_cnt <= pkt_cnt + (PTR_W+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (PTR_W+1)'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase

      if (v_flit_in && !req_fifo_rdy)         ovf_err   <= 1'b1;
      if (v_flit_in && req_fifo_rdy && !legal) proto_err <= 1'b1;
    end
  end

  // data array needs no reset: nothing is read until a complete packet exists
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ctrl_in, flit_in};
  end

endmodule

// File: tb/tb_m_req_flit_fifo.sv
module tb_m_req_flit_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] flit_in;
  logic [1:0]  ctrl_in;
  logic        v_flit_in;
  logic        req_fifo_rdy;
  logic [15:0] flit_out;
  logic [1:0]  ctrl_out;
  logic        v_flit_out;
  logic        ring_rdy_in;
  logic [4:0]  pkt_cnt;
  logic        proto_err;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_req_flit_fifo #(.DEPTH(16), .PTR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_in      (flit_in),
    .ctrl_in      (ctrl_in),
    .v_flit_in    (v_flit_in),
    .req_fifo_rdy (req_fifo_rdy),
    .flit_out     (flit_out),
    .ctrl_out     (ctrl_out),
    .v_flit_out   (v_flit_out),
    .ring_rdy_in  (ring_rdy_in),
    .pkt_cnt      (pkt_cnt),
    .proto_err    (proto_err),
    .ovf_err      (ovf_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [1:0] c, input logic [15:0] f);
    v_flit_in = v;
    ctrl_in   = c;
    flit_in   = f;
  endtask

  task automatic do_reset();
    put(1'b0, 2'b00, 16'h0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [1:0] stream_ctrl(input int k);
    case (k % 4)
      0:       return 2'b01;
      3:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic test_reset();
    ring_rdy_in = 1'b0;
    do_reset();
    checks++; if (v_flit_out !== 1'b0)   begin errors++; $display("FAIL reset_vld got %b exp 0", v_flit_out); end
    checks++; if (req_fifo_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", req_fifo_rdy); end
    checks++; if (pkt_cnt !== 5'd0)      begin errors++; $display("FAIL reset_pkt got %0d exp 0", pkt_cnt); end
    checks++; if (proto_err !== 1'b0)    begin errors++; $display("FAIL reset_proto got %b exp 0", proto_err); end
    checks++; if (ovf_err !== 1'b0)      begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
  endtask

  task automatic test_basic();
    logic [15:0] ef [3] = '{16'hA001, 16'h1234, 16'h5678};
    logic [1:0]  ec [3] = '{2'b01, 2'b10, 2'b11};
    ring_rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, ec[i], ef[i]);
      tick();
      if (i < 2) begin
        checks++; if (v_flit_out !== 1'b0) begin errors++; $display("FAIL basic_early_vld step %0d got %b exp 0", i, v_flit_out); end
        checks++; if (pkt_cnt !== 5'd0)    begin errors++; $display("FAIL basic_early_pkt step %0d got %0d exp 0", i, pkt_cnt); end
      end
    end
    put(1'b0, 2'b00, 16'h0);
    checks++; if (pkt_cnt !== 5'd1) begin errors++; $display("FAIL basic_pkt_after_tail got %0d exp 1", pkt_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (v_flit_out !== 1'b1)   begin errors++; $display("FAIL basic_vld out %0d got %b exp 1", i, v_flit_out); end
      checks++; if (flit_out !== ef[i])    begin errors++; $display("FAIL basic_flit out %0d got %h exp %h", i, flit_out, ef[i]); end
      checks++; if (ctrl_out !== ec[i])    begin errors++; $display("FAIL basic_ctrl out %0d got %b exp %b", i, ctrl_out, ec[i]); end
      checks++; if (req_fifo_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy out %0d got %b exp 1", i, req_fifo_rdy); end
      tick();
    end
    checks++; if (v_flit_out !== 1'b0) begin errors++; $display("FAIL basic_vld_end got %b exp 0", v_flit_out); end
    checks++; if (pkt_cnt !== 5'd0)    begin errors++; $display("FAIL basic_pkt_end got %0d exp 0", pkt_cnt); end
    ring_rdy_in = 1'b0;
  endtask

  task automatic test_full();
    logic [15:0] f;
    logic [1:0]  c;
    ring_rdy_in = 1'b0;
    // 11-flit packet 0x1100..0x110A then 5 flits of a second packet 0x2200..0x2204
    for (int i = 0; i < 16; i++) begin
      if (i < 11) begin
        f = 16'h1100 + 16'(i);
        c = (i == 0) ? 2'b01 : ((i == 10) ? 2'b11 : 2'b10);
      end else begin
        f = 16'h2200 + 16'(i - 11);
        c = (i == 11) ? 2'b01 : 2'b10;
      end
      checks++; if (req_fifo_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_fill %0d got %b exp 1", i, req_fifo_rdy); end
      put(1'b1, c, f);
      tick();
    end
    checks++; if (req_fifo_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_low got %b exp 0", req_fifo_rdy); end
    checks++; if (pkt_cnt !== 5'd1)      begin errors++; $display("FAIL full_pkt got %0d exp 1", pkt_cnt); end
    put(1'b1, 2'b10, 16'hDEAD);
    tick();
    put(1'b0, 2'b00, 16'h0);
    checks++; if (ovf_err !== 1'b1)   begin errors++; $display("FAIL full_ovf got %b exp 1", ovf_err); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL full_proto got %b exp 0", proto_err); end
    checks++; if (pkt_cnt !== 5'd1)   begin errors++; $display("FAIL full_pkt_after_ovf got %0d exp 1", pkt_cnt); end
    ring_rdy_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      f = 16'h1100 + 16'(i);
      c = (i == 0) ? 2'b01 : ((i == 10) ? 2'b11 : 2'b10);
      checks++; if (v_flit_out !== 1'b1) begin errors++; $display("FAIL full_drain_vld %0d got %b exp 1", i, v_flit_out); end
      checks++; if (flit_out !== f)      begin errors++; $display("FAIL full_drain_flit %0d got %h exp %h", i, flit_out, f); end
      checks++; if (ctrl_out !== c)      begin errors++; $display("FAIL full_drain_ctrl %0d got %b exp %b", i, ctrl_out, c); end
      tick();
    end
    ring_rdy_in = 1'b0;
    checks++; if (v_flit_out !== 1'b0)   begin errors++; $display("FAIL full_vld_gap got %b exp 0", v_flit_out); end
    checks++; if (pkt_cnt !== 5'd0)      begin errors++; $display("FAIL full_pkt_gap got %0d exp 0", pkt_cnt); end
    checks++; if (req_fifo_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after got %b exp 1", req_fifo_rdy); end
    // finish the second packet; the dropped 0xDEAD must not appear
    put(1'b1, 2'b11, 16'h22FF);
    tick();
    put(1'b0, 2'b00, 16'h0);
    ring_rdy_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f = (i == 5) ? 16'h22FF : 16'h2200 + 16'(i);
      c = (i == 0) ? 2'b01 : ((i == 5) ? 2'b11 : 2'b10);
      checks++; if (v_flit_out !== 1'b1) begin errors++; $display("FAIL full_p2_vld %0d got %b exp 1", i, v_flit_out); end
      checks++; if (flit_out !== f)      begin errors++; $display("FAIL full_p2_flit %0d got %h exp %h", i, flit_out, f); end
      checks++; if (ctrl_out !== c)      begin errors++; $display("FAIL full_p2_ctrl %0d got %b exp %b", i, ctrl_out, c); end
      tick();
    end
    checks++; if (v_flit_out !== 1'b0) begin errors++; $display("FAIL full_p2_end got %b exp 0", v_flit_out); end
    ring_rdy_in = 1'b0;
  endtask

  task automatic test_proto();
    logic [15:0] ef [3] = '{16'hC001, 16'hC002, 16'hC003};
    logic [1:0]  ec [3] = '{2'b01, 2'b10, 2'b11};
    do_reset();
    ring_rdy_in = 1'b0;
    put(1'b1, 2'b11, 16'hBAD0);
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_tail_first got %b exp 1", proto_err); end
    checks++; if (pkt_cnt !== 5'd0)   begin errors++; $display("FAIL proto_tail_pkt got %0d exp 0", pkt_cnt); end
    put(1'b1, 2'b00, 16'hBAD2);
    tick();
    put(1'b1, 2'b01, 16'hC001);
    tick();
    put(1'b1, 2'b01, 16'hBAD1);
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_head_in_pkt got %b exp 1", proto_err); end
    put(1'b1, 2'b10, 16'hC002);
    tick();
    put(1'b1, 2'b11, 16'hC003);
    tick();
    put(1'b0, 2'b00, 16'h0);
    checks++; if (pkt_cnt !== 5'd1)   begin errors++; $display("FAIL proto_pkt got %0d exp 1", pkt_cnt); end
    checks++; if (ovf_err !== 1'b0)   begin errors++; $display("FAIL proto_ovf got %b exp 0", ovf_err); end
    ring_rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (v_flit_out !== 1'b1) begin errors++; $display("FAIL proto_vld %0d got %b exp 1", i, v_flit_out); end
      checks++; if (flit_out !== ef[i])  begin errors++; $display("FAIL proto_flit %0d got %h exp %h", i, flit_out, ef[i]); end
      checks++; if (ctrl_out !== ec[i])  begin errors++; $display("FAIL proto_ctrl %0d got %b exp %b", i, ctrl_out, ec[i]); end
      tick();
    end
    checks++; if (v_flit_out !== 1'b0) begin errors++; $display("FAIL proto_vld_end got %b exp 0", v_flit_out); end
    checks++; if (proto_err !== 1'b1)  begin errors++; $display("FAIL proto_sticky got %b exp 1", proto_err); end
    ring_rdy_in = 1'b0;
  endtask

  // 40 flits as ten 4-flit packets with ring always ready; each tail read
  // coincides with the next tail write, so pkt_cnt holds at 1.
  task automatic test_back_to_back();
    int oi = 0;
    ring_rdy_in = 1'b1;
    for (int i = 0; i < 44; i++) begin
      if (i < 40) put(1'b1, stream_ctrl(i), 16'h3000 + 16'(i));
      else        put(1'b0, 2'b00, 16'h0);
      checks++; if (v_flit_out !== (i >= 4))            begin errors++; $display("FAIL b2b_vld cyc %0d got %b exp %b", i, v_flit_out, (i >= 4)); end
      checks++; if (pkt_cnt !== ((i >= 4) ? 5'd1 : 5'd0)) begin errors++; $display("FAIL b2b_pkt cyc %0d got %0d", i, pkt_cnt); end
      checks++; if (req_fifo_rdy !== 1'b1)              begin errors++; $display("FAIL b2b_rdy cyc %0d got %b exp 1", i, req_fifo_rdy); end
      if (v_flit_out === 1'b1) begin
        checks++; if (flit_out !== 16'h3000 + 16'(oi))  begin errors++; $display("FAIL b2b_flit %0d got %h exp %h", oi, flit_out, 16'h3000 + 16'(oi)); end
        checks++; if (ctrl_out !== stream_ctrl(oi))     begin errors++; $display("FAIL b2b_ctrl %0d got %b exp %b", oi, ctrl_out, stream_ctrl(oi)); end
        oi++;
      end
      tick();
    end
    checks++; if (oi != 40)            begin errors++; $display("FAIL b2b_count got %0d exp 40", oi); end
    checks++; if (v_flit_out !== 1'b0) begin errors++; $display("FAIL b2b_vld_end got %b exp 0", v_flit_out); end
    checks++; if (pkt_cnt !== 5'd0)    begin errors++; $display("FAIL b2b_pkt_end got %0d exp 0", pkt_cnt); end
    ring_rdy_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] ef [7] = '{16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005, 16'hD006, 16'hD007};
    logic [1:0]  ec [7] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10};
    ring_rdy_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      put(1'b1, ec[i], ef[i]);
      tick();
    end
    put(1'b1, 2'b01, 16'hBAD3);
    tick();
    put(1'b0, 2'b00, 16'h0);
    checks++; if (pkt_cnt !== 5'd1)   begin errors++; $display("FAIL mid_pkt_before got %0d exp 1", pkt_cnt); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mid_proto_before got %b exp 1", proto_err); end
    do_reset();
    checks++; if (pkt_cnt !== 5'd0)      begin errors++; $display("FAIL mid_pkt got %0d exp 0", pkt_cnt); end
    checks++; if (v_flit_out !== 1'b0)   begin errors++; $display("FAIL mid_vld got %b exp 0", v_flit_out); end
    checks++; if (req_fifo_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b exp 1", req_fifo_rdy); end
    checks++; if (proto_err !== 1'b0)    begin errors++; $display("FAIL mid_proto got %b exp 0", proto_err); end
    checks++; if (ovf_err !== 1'b0)      begin errors++; $display("FAIL mid_ovf got %b exp 0", ovf_err); end
    // checker must be back in WAIT_HEAD: a body is illegal
    put(1'b1, 2'b10, 16'hE000);
    tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mid_body_after_reset got %b exp 1", proto_err); end
    put(1'b1, 2'b01, 16'hE001);
    tick();
    put(1'b1, 2'b11, 16'hE002);
    tick();
    put(1'b0, 2'b00, 16'h0);
    checks++; if (v_flit_out !== 1'b1)  begin errors++; $display("FAIL mid_new_vld got %b exp 1", v_flit_out); end
    checks++; if (flit_out !== 16'hE001) begin errors++; $display("FAIL mid_new_head got %h exp e001", flit_out); end
    ring_rdy_in = 1'b1;
    tick();
    checks++; if (flit_out !== 16'hE002) begin errors++; $display("FAIL mid_new_tail got %h exp e002", flit_out); end
    checks++; if (ctrl_out !== 2'b11)    begin errors++; $display("FAIL mid_new_tail_ctrl got %b exp 11", ctrl_out); end
    tick();
    checks++; if (v_flit_out !== 1'b0)  begin errors++; $display("FAIL mid_new_end got %b exp 0", v_flit_out); end
    ring_rdy_in = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    ring_rdy_in = 1'b0;
    put(1'b0, 2'b00, 16'h0);
    test_reset();
    test_basic();
    test_full();
    test_proto();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
